// File: rtl/spi_wb_master.sv
// SPI-slave command port that runs single Wishbone classic cycles for a host.
// Frames: 0x01 write (addr, data, status) and 0x02 read (addr, pad, status, data), big-endian.
module spi_wb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SELECT_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_sclk_i,
  input  logic                    spi_cs_n_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy_o
);

  localparam int unsigned TMO_W    = 6;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ST_ACK    = 8'hA5;
  localparam logic [7:0] ST_ERR    = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_BUS, S_TX, S_DROP
  } state_e;

  state_e state_q, state_d;

  logic sclk_m_q, sclk_s_q, sclk_h_q;
  logic cs_m_q, cs_s_q, cs_h_q;
  logic mosi_m_q, mosi_s_q;

  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [3:0]              byte_cnt_q, byte_cnt_d;
  logic [6:0]              rx_sr_q, rx_sr_d;
  logic [7:0]              tx_sr_q, tx_sr_d;
  logic [31:0]             addr_sr_q, addr_sr_d;
  logic [23:0]             data_sr_q, data_sr_d;
  logic                    is_read_q, is_read_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    discard_q, discard_d;
  logic [7:0]              status_q, status_d;
  logic [31:0]             rdata_q, rdata_d;

  logic       sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c, active_c;
  logic       byte_done_c, bus_end_c, start_c, reject_c;
  logic [7:0] rx_byte_c, next_byte_c;

  assign active_c    = (state_q != S_IDLE) && !cs_s_q;
  assign sclk_rise_c = active_c && sclk_s_q && !sclk_h_q;
  assign sclk_fall_c = active_c && !sclk_s_q && sclk_h_q;
  assign cs_fall_c   = !cs_s_q && cs_h_q;
  assign cs_rise_c   = cs_s_q && !cs_h_q;
  assign rx_byte_c   = {rx_sr_q, mosi_s_q};
  assign byte_done_c = sclk_rise_c && (bit_cnt_q == 3'd7);
  assign bus_end_c   = cyc_q && (wb_ack_i || wb_err_i || (tmo_q == TMO_LAST));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a high chip select always parks the SPI side in IDLE
  always_comb begin
    state_d = state_q;
    if (cs_s_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall_c) state_d = S_CMD;
        S_CMD:   if (byte_done_c)
                   state_d = (rx_byte_c == CMD_WRITE || rx_byte_c == CMD_READ) ? S_ADDR : S_DROP;
        S_ADDR:  if (byte_done_c && byte_cnt_q == 4'd4)
                   state_d = !is_read_q ? S_WDATA : (cyc_q ? S_TX : S_BUS);
        S_WDATA: if (byte_done_c && byte_cnt_q == 4'd8)
                   state_d = cyc_q ? S_TX : S_BUS;
        S_BUS:   if (bus_end_c) state_d = S_TX;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and bus outputs
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    is_read_d   = is_read_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    discard_d   = discard_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    next_byte_c = 8'h00;
    start_c     = (state_d == S_BUS) && (state_q != S_BUS);
    reject_c    = (state_d == S_TX) && (state_q == S_ADDR || state_q == S_WDATA);

    if (cs_fall_c) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      rx_sr_d    = 7'd0;
    end else if (sclk_rise_c) begin
      rx_sr_d   = rx_byte_c[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7 && byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
    end

    if (byte_done_c && state_q == S_CMD)   is_read_d = (rx_byte_c == CMD_READ);
    if (byte_done_c && state_q == S_ADDR)  addr_sr_d = {addr_sr_q[23:0], rx_byte_c};
    if (byte_done_c && state_q == S_WDATA) data_sr_d = {data_sr_q[15:0], rx_byte_c};

    // Response byte selected by the index of the byte about to be shifted out
    if (state_q == S_DROP) begin
      next_byte_c = 8'hFF;
    end else if (is_read_q) begin
      case (byte_cnt_q)
        4'd6:    next_byte_c = status_q;
        4'd7:    next_byte_c = rdata_q[31:24];
        4'd8:    next_byte_c = rdata_q[23:16];
        4'd9:    next_byte_c = rdata_q[15:8];
        4'd10:   next_byte_c = rdata_q[7:0];
        default: next_byte_c = 8'h00;
      endcase
    end else if (byte_cnt_q == 4'd9) begin
      next_byte_c = status_q;
    end

    if (cs_fall_c || cs_rise_c) begin
      tx_sr_d = 8'h00;
    end else if (sclk_fall_c) begin
      tx_sr_d = (bit_cnt_q == 3'd0) ? next_byte_c : {tx_sr_q[6:0], 1'b0};
    end

    // A cycle orphaned by chip-select rise still completes but its result is dropped
    if (start_c) begin
      cyc_d     = 1'b1;
      tmo_d     = '0;
      discard_d = 1'b0;
      we_d      = !is_read_q;
      sel_d     = '1;
      adr_d     = is_read_q ? ADDR_WIDTH'({addr_sr_q[23:0], rx_byte_c})
                            : ADDR_WIDTH'(addr_sr_q);
      if (!is_read_q) dat_d = DATA_WIDTH'({data_sr_q, rx_byte_c});
    end else if (cyc_q) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (cs_rise_c) discard_d = 1'b1;
      if (bus_end_c) begin
        cyc_d = 1'b0;
        if (!discard_d) begin
          status_d = (wb_ack_i && !wb_err_i) ? ST_ACK : ST_ERR;
          if (!we_q) rdata_d = (wb_ack_i && !wb_err_i) ? 32'(wb_dat_i) : 32'd0;
        end
      end
    end
    if (reject_c) status_d = ST_ERR;
  end

  // Synchronisers and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_m_q <= 1'b0; sclk_s_q <= 1'b0; sclk_h_q <= 1'b0;
      cs_m_q   <= 1'b0; cs_s_q   <= 1'b0; cs_h_q   <= 1'b0;
      mosi_m_q <= 1'b0; mosi_s_q <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      is_read_q  <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      tmo_q      <= '0;
      discard_q  <= 1'b0;
      status_q   <= '0;
      rdata_q    <= '0;
    end else begin
      sclk_m_q <= spi_sclk_i; sclk_s_q <= sclk_m_q; sclk_h_q <= sclk_s_q;
      cs_m_q   <= spi_cs_n_i; cs_s_q   <= cs_m_q;   cs_h_q   <= cs_s_q;
      mosi_m_q <= spi_mosi_i; mosi_s_q <= mosi_m_q;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      is_read_q  <= is_read_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      tmo_q      <= tmo_d;
      discard_q  <= discard_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
    end
  end

  assign spi_miso_o = tx_sr_q[7];
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_stb_o   = cyc_q;
  assign wb_cyc_o   = cyc_q;
  assign busy_o     = cyc_q;

endmodule

// File: tb/tb_spi_wb_master.sv
// Bench for spi_wb_master: SPI host driver, Wishbone slave model and bus/MISO scoreboards.
module tb_spi_wb_master;

  localparam int unsigned HALF = 8;
  localparam int unsigned TMO  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err, busy;
  logic [3:0]  wb_sel;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        chk_dat;
    logic        chk_len;
    logic [7:0]  len;
  } bus_exp_t;

  int          checks = 0;
  int          errors = 0;
  bus_exp_t    exp_bus_q[$];
  logic [7:0]  exp_miso_q[$];
  logic [7:0]  tx_buf [0:10];
  logic [7:0]  ex_buf [0:10];
  int unsigned slv_mode = 0;
  logic [31:0] slv_reg;

  spi_wb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_sclk_i(spi_sclk), .spi_cs_n_i(spi_cs_n), .spi_mosi_i(spi_mosi), .spi_miso_o(spi_miso),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Slave: mode 0 acks one clk after strobe, 1 never responds, 2 raises ack and err together
  always @(posedge clk) begin
    if (!rst) begin
      wb_ack  <= 1'b0;
      wb_err  <= 1'b0;
      slv_reg <= 32'd0;
    end else begin
      wb_ack <= wb_cyc & wb_stb & ~wb_ack & ~wb_err & (slv_mode != 1);
      wb_err <= wb_cyc & wb_stb & ~wb_ack & ~wb_err & (slv_mode == 2);
      if (wb_cyc & wb_stb & wb_we & wb_ack & ~wb_err) slv_reg <= wb_dat_o;
    end
  end
  assign wb_dat_i = slv_reg;

  // Bus monitor: pops the expected cycle on cyc rise, checks its length on cyc fall
  logic       cyc_prev = 1'b0;
  logic [7:0] cyc_len  = 8'd0;
  bus_exp_t   cur      = '0;
  always @(negedge clk) begin
    if (wb_cyc && !cyc_prev) begin
      if (exp_bus_q.size() == 0) begin
        check("unexp_cyc", 32'(wb_cyc), 32'd0);
        cur = '0;
      end else begin
        cur = exp_bus_q.pop_front();
        check("bus_we",   32'(wb_we), 32'(cur.we));
        check("bus_adr",  wb_adr, cur.adr);
        check("bus_sel",  32'(wb_sel), 32'hF);
        check("bus_stb",  32'(wb_stb), 32'd1);
        check("bus_busy", 32'(busy), 32'd1);
        if (cur.chk_dat) check("bus_dat", wb_dat_o, cur.dat);
      end
      cyc_len = 8'd1;
    end else if (wb_cyc) begin
      cyc_len = cyc_len + 8'd1;
    end else if (cyc_prev && cur.chk_len) begin
      check("cyc_len", 32'(cyc_len), 32'(cur.len));
    end
    cyc_prev = wb_cyc;
  end

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input string name);
    logic [7:0] rx;
    logic [7:0] exp;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      exp_miso_q.push_back(ex_buf[k]);
      spi_xfer(tx_buf[k], rx);
      exp = exp_miso_q.pop_front();
      check($sformatf("%s_miso%0d", name, k), 32'(rx), 32'(exp));
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic build_write(input logic [31:0] adr, input logic [31:0] dat, input logic [7:0] st);
    for (int k = 0; k < 11; k++) begin
      tx_buf[k] = 8'h00;
      ex_buf[k] = 8'h00;
    end
    tx_buf[0] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tx_buf[1 + k] = adr[31 - 8 * k -: 8];
      tx_buf[5 + k] = dat[31 - 8 * k -: 8];
    end
    ex_buf[9] = st;
  endtask

  task automatic build_read(input logic [31:0] adr, input logic [7:0] st, input logic [31:0] dat);
    for (int k = 0; k < 11; k++) begin
      tx_buf[k] = 8'h00;
      ex_buf[k] = 8'h00;
    end
    tx_buf[0] = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tx_buf[1 + k] = adr[31 - 8 * k -: 8];
      ex_buf[7 + k] = dat[31 - 8 * k -: 8];
    end
    ex_buf[6] = st;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic chk_dat, input logic chk_len, input logic [7:0] len);
    bus_exp_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    e.chk_dat = chk_dat; e.chk_len = chk_len; e.len = len;
    exp_bus_q.push_back(e);
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_cyc",  32'(wb_cyc), 32'd0);
    check("rst_stb",  32'(wb_stb), 32'd0);
    check("rst_we",   32'(wb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_adr",  wb_adr, 32'd0);
    check("rst_dat",  wb_dat_o, 32'd0);
    check("rst_sel",  32'(wb_sel), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    build_write(32'h0, 32'h0000002A, 8'hA5);
    push_bus(1'b1, 32'h0, 32'h0000002A, 1'b1, 1'b1, 8'd2);
    send_frame(10, "wr1");

    build_read(32'h0, 8'hA5, 32'h0000002A);
    push_bus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'd2);
    send_frame(11, "rd1");

    slv_mode = 1;
    build_read(32'h0, 8'hEE, 32'h0);
    push_bus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'(TMO));
    send_frame(11, "rd_tmo");

    slv_mode = 2;
    build_write(32'h12345678, 32'hDEADBEEF, 8'hEE);
    push_bus(1'b1, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b1, 8'd2);
    send_frame(10, "wr_err");
    slv_mode = 0;

    build_write(32'h0, 32'h0, 8'h00);
    tx_buf[0] = 8'h7F;
    for (int k = 1; k < 4; k++) ex_buf[k] = 8'hFF;
    send_frame(4, "badcmd");

    build_write(32'h0, 32'h0, 8'h00);
    send_frame(3, "partial");

    build_write(32'h00000004, 32'hCAFEF00D, 8'hA5);
    push_bus(1'b1, 32'h00000004, 32'hCAFEF00D, 1'b1, 1'b1, 8'd2);
    send_frame(10, "wr2");

    build_read(32'h00000004, 8'hA5, 32'hCAFEF00D);
    push_bus(1'b0, 32'h00000004, 32'h0, 1'b0, 1'b1, 8'd2);
    send_frame(11, "rd2");

    // Reset while a bus cycle is outstanding
    slv_mode = 1;
    build_write(32'h00000008, 32'h11223344, 8'h00);
    push_bus(1'b1, 32'h00000008, 32'h11223344, 1'b1, 1'b0, 8'd0);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 9; k++) spi_xfer(tx_buf[k], rx);
    repeat (4) @(negedge clk);
    check("cyc_pre_rst", 32'(wb_cyc), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("bus_rst_cyc",  32'(wb_cyc), 32'd0);
    check("bus_rst_stb",  32'(wb_stb), 32'd0);
    check("bus_rst_busy", 32'(busy), 32'd0);
    check("bus_rst_miso", 32'(spi_miso), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    spi_cs_n = 1'b1;
    slv_mode = 0;
    repeat (4 * HALF) @(negedge clk);

    // Reset mid-frame while MISO is driving 0xFF
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_xfer(8'h7F, rx);
    repeat (6) @(negedge clk);
    check("miso_pre_rst", 32'(spi_miso), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("frm_rst_miso", 32'(spi_miso), 32'd0);
    check("frm_rst_cyc",  32'(wb_cyc), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);

    build_write(32'h00000010, 32'h55AA33CC, 8'hA5);
    push_bus(1'b1, 32'h00000010, 32'h55AA33CC, 1'b1, 1'b1, 8'd2);
    send_frame(10, "wr3");

    build_read(32'h00000010, 8'hA5, 32'h55AA33CC);
    push_bus(1'b0, 32'h00000010, 32'h0, 1'b0, 1'b1, 8'd2);
    send_frame(11, "rd3");

    check("bus_q_left", 32'(exp_bus_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
